// File: rtl/mat_vec_stream.sv
// mat_vec_stream
//   Streaming DIM x DIM fixed-point matrix-vector multiplier. A matrix is
//   loaded once, then any number of vectors are multiplied against it, one
//   result row per clock. Results are scaled by 2^-FRAC with floor rounding
//   and either saturated or wrapped to WIDTH bits, with a per-row overflow flag.
//
// Ports
//   clk_in     rising-edge clock
//   rst_in     asynchronous active-high reset
//   m_load     matrix load strobe, taken only while m_ready=1
//   m_ready    high while idle (matrix may be loaded)
//   m_in       matrix, packed [row][col][bit]
//   in_valid   input vector valid
//   in_ready   input vector accepted when high together with in_valid
//   v_in       input vector, packed [elem][bit]
//   out_valid  result vector valid, held until out_ready
//   out_ready  downstream accept
//   v_out      result vector, packed [elem][bit]
//   ovf_out    per-element overflow flag, qualified by out_valid

module mat_vec_stream #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 16,
    parameter int DIM      = 4,
    parameter int SATURATE = 1
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic                                 m_load,
    output logic                                 m_ready,
    input  logic [DIM-1:0][DIM-1:0][WIDTH-1:0]   m_in,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DIM-1:0][WIDTH-1:0]            v_in,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DIM-1:0][WIDTH-1:0]            v_out,
    output logic [DIM-1:0]                       ovf_out
);

    localparam int ROW_W = $clog2(DIM);
    // Wide enough for the sum of DIM full-width products without loss.
    localparam int ACC_W = 2 * WIDTH + ROW_W;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        OUTPUT
    } state_t;

    state_t                            state_q, state_d;
    logic [DIM-1:0][DIM-1:0][WIDTH-1:0] mat_q;
    logic [DIM-1:0][WIDTH-1:0]          vec_q;
    logic [ROW_W-1:0]                  row_q;
    logic                              m_loaded_q;
    logic                              load;
    logic                              accept;

    logic signed [ACC_W-1:0]           acc;
    logic signed [ACC_W-1:0]           shifted;
    logic [WIDTH-1:0]                  row_res;
    logic                              row_ovf;

    assign m_ready   = (state_q == IDLE);
    // A load in the same cycle takes priority; the vector waits a cycle.
    assign in_ready  = m_ready && m_loaded_q && !m_load;
    assign out_valid = (state_q == OUTPUT);
    assign load      = m_ready && m_load;
    assign accept    = in_valid && in_ready;

    // One row of the product per cycle: dot product of mat_q[row_q] with vec_q.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        acc = '0;
        for (int c = 0; c < DIM; c++) begin
            acc = acc + ACC_W'($signed(mat_q[row_q][c])) * ACC_W'($signed(vec_q[c]));
        end
        // Arithmetic shift gives floor rounding (toward negative infinity).
        shifted = acc >>> FRAC;
        // In range only if every bit from the WIDTH sign bit upward agrees.
        row_ovf = !((&shifted[ACC_W-1:WIDTH-1]) || !(|shifted[ACC_W-1:WIDTH-1]));
        if (row_ovf && (SATURATE != 0)) begin
            row_res = shifted[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            row_res = shifted[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments so
            // every register samples pre-edge values, independent of block order.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)                     state_d = COMPUTE;
            COMPUTE: if (row_q == ROW_W'(DIM - 1))   state_d = OUTPUT;
            OUTPUT:  if (out_ready)                  state_d = IDLE;
            default:                                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            // NOTE: the matrix register is reset on purpose: a reset must force a
            // reload, and a cleared matrix makes any stale use visible as zeros.
            mat_q      <= '0;
            m_loaded_q <= 1'b0;
            vec_q      <= '0;
            row_q      <= '0;
            v_out      <= '0;
            ovf_out    <= '0;
        end else begin
            if (load) begin
                mat_q      <= m_in;
                m_loaded_q <= 1'b1;
            end
            if (accept) begin
                vec_q   <= v_in;
                row_q   <= '0;
                ovf_out <= '0;
            end
            // v_out is written only here, so it holds steady through OUTPUT
            // and keeps the last result while idle.
            if (state_q == COMPUTE) begin
                v_out[row_q]   <= row_res;
                ovf_out[row_q] <= row_ovf;
                row_q          <= row_q + ROW_W'(1);
            end
        end
    end

endmodule

// File: doc/mat_vec_stream.md
# mat_vec_stream

Parametrised, streaming successor to the fixed 4x4 Q16.16 matrix-vector multiplier used in the transform path. It holds a DIM x DIM matrix loaded once and then multiplies any number of vectors against it, one row per clock. It uses ready/valid handshakes on input and output, so it sits directly between the vertex fetch stage and the projection stage. Scaling is configurable, and so is overflow handling (saturate or wrap), with a per-element overflow flag.

## Interface
- WIDTH, 32: element width, two's complement signed.
- FRAC, 16: fractional bits (Q(WIDTH-FRAC).FRAC); 0 = integer mode.
- DIM, 4: matrix/vector dimension, 2..8.
- SATURATE, 1: 1 = clamp results to signed WIDTH range; 0 = wrap (keep low WIDTH bits).
- clk_in  input  1  single clock, rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- m_load  input  1  matrix load strobe; honoured only while m_ready=1.
- m_ready  output  1  high in IDLE.
- m_in  input  DIM*DIM*WIDTH  matrix, packed [DIM-1:0][DIM-1:0][WIDTH-1:0], index [row][col].
- in_valid  input  1  vector valid.
- in_ready  output  1  vector accept.
- v_in  input  DIM*WIDTH  input vector, packed [DIM-1:0][WIDTH-1:0].
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accept.
- v_out  output  DIM*WIDTH  result vector.
- ovf_out  output  DIM  per-element overflow flag, qualified by out_valid.

## Operation
- The FSM has three states: IDLE, COMPUTE and OUTPUT.
- Matrix load:
  - m_load with m_ready=1 latches m_in into the internal matrix register and sets m_loaded.
  - m_load in any other state is ignored.
  - m_loaded persists across vectors; only reset clears it.
- in_ready = (state==IDLE) && m_loaded && !m_load. When m_load and in_valid arrive in the same cycle, the load wins and the vector waits.
- On in_valid && in_ready:
  - latch v_in;
  - set row counter r=0;
  - go to COMPUTE.
- COMPUTE, one row per cycle:
  - Form the products m[r][c]*v[c] as 2*WIDTH signed values.
  - Sum them in a 2*WIDTH+clog2(DIM) accumulator.
  - Arithmetic-shift right by FRAC; this is floor rounding, toward negative infinity.
  - If the shifted value is outside the signed WIDTH range:
    - with SATURATE=1, write 2^(WIDTH-1)-1 or -2^(WIDTH-1);
    - with SATURATE=0, write the low WIDTH bits.
  - In either mode, set ovf_out[r]=1.
  - Write the result to v_out[r] and increment r.
  - At r==DIM-1, go to OUTPUT.
- OUTPUT: out_valid=1. v_out and ovf_out are held stable until out_valid && out_ready, then the FSM returns to IDLE.
- ovf_out is cleared at each vector acceptance.
- v_out is only written in COMPUTE, so it retains the last result while IDLE.

## Timing
- Reset values, applied immediately and asynchronously:
  - state=IDLE, m_loaded=0;
  - matrix register = 0, v_out = 0, ovf_out = 0;
  - out_valid=0, in_ready=0, m_ready=1 once reset is released.
- Reset asserted mid-COMPUTE or mid-OUTPUT drops the in-flight vector with no out_valid, and the matrix must be reloaded.
- Latency: the vector accepted at edge E0 writes its rows at edges E1..E_DIM. out_valid is high from edge E_DIM onward, which is DIM cycles after the accept.
- Throughput:
  - The OUTPUT handshake at edge Ek returns the FSM to IDLE, and in_ready is high in the cycle after Ek.
  - Peak rate is one vector per DIM+2 cycles.
- out_valid stays high until accepted. v_out must not change while out_valid=1 && !out_ready.
- in_ready and m_ready are low throughout COMPUTE and OUTPUT.
- out_ready is ignored outside OUTPUT.

## Test plan
- **Basic Q16.16 result** (WIDTH=32, FRAC=16, DIM=4).
  - Load m = {{1,2,3,4},{5,6.5,7.75,8},{9,10,-26.25,12},{13,14.125,15,16}} and apply v = {-3.5,6.5,7.75,12}.
  - Required: v_out = {0x0050C000, 0x00B4D000, 0xFFE61000, 0x01629000}, i.e. {80.75, 180.8125, -25.9375, 354.5625}.
  - Required: ovf_out = 0, and out_valid rises exactly 4 cycles after the accept.
- **Saturation** (SATURATE=1): m = 32767.0·I (0x7FFF0000 diagonal), v = all 2.0 (0x00020000) -> every v_out = 0x7FFFFFFF, ovf_out = 4'b1111.
- **Wrap** (SATURATE=0): same stimulus as the saturation case -> every v_out = 0xFFFE0000 (-2.0), ovf_out = 4'b1111.
- **Floor rounding**: m[0][0] = 0x00008000 (0.5), all other entries 0; v[0] = 0xFFFFFFFF -> v_out[0] = 0xFFFFFFFF, all other v_out = 0.
- **Back-pressure and streaming**:
  - Stream three vectors against one matrix, holding out_ready low for 5 cycles on the second.
  - Required: v_out is stable while stalled, in_ready stays low, and the three results appear in order with no drops.
  - m_load pulsed during COMPUTE is ignored.
- **Reset and priority**:
  - Assert rst_in mid-COMPUTE -> out_valid=0, v_out=0 asynchronously; in_ready stays 0 until a new m_load.
  - Simultaneous m_load and in_valid in IDLE -> the matrix is loaded first and the vector is accepted on the next cycle, against the new matrix.
